// File: rtl/router_input_unit.sv
// Per-port router input stage: flit FIFO plus per-packet route latch.
// The route is captured from the head flit and held until the tail leaves.
module router_input_unit #(
  parameter int X_WIDTH    = 2,
  parameter int Y_WIDTH    = 2,
  parameter int FLIT_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [FLIT_WIDTH-1:0]      in_flit,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [X_WIDTH-1:0]         route_dst_x,
  output logic [Y_WIDTH-1:0]         route_dst_y,
  input  logic [2:0]                 route_sel_in,
  output logic [FLIT_WIDTH-1:0]      out_flit,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2:0]                 out_route,
  output logic                       out_tail,
  output logic                       err_drop,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  logic [FLIT_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [2:0]            route_q, route_d;
  state_t                state_q, state_d;

  logic [FLIT_WIDTH-1:0] head;
  logic [1:0]            head_type;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  hs;

  assign head      = mem_q[rd_ptr_q];
  assign head_type = head[FLIT_WIDTH-1:FLIT_WIDTH-2];
  assign empty     = (count_q == '0);

  assign in_ready  = rst_n && (count_q != CW'(DEPTH));
  assign push      = in_valid && in_ready;

  assign out_valid = rst_n && (state_q == ACTIVE) && !empty;
  assign hs        = out_valid && out_ready;

  // Body/tail at the head while idle has no route: discard it.
  assign err_drop  = rst_n && (state_q == IDLE) && !empty
                     && !head_type[0];
  assign pop       = hs || err_drop;

  assign out_flit    = head;
  assign out_route   = route_q;
  assign out_tail    = (state_q == ACTIVE) && head_type[1];
  assign route_dst_x = head[X_WIDTH-1:0];
  assign route_dst_y = head[X_WIDTH+Y_WIDTH-1:X_WIDTH];
  assign count       = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    route_d  = route_q;
    state_d  = state_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (!empty && head_type[0]) begin
          route_d = route_sel_in;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (hs && head_type[1]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      route_q  <= '0;
      state_q  <= IDLE;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      route_q  <= route_d;
      state_q  <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_flit;
  end

endmodule

// File: tb/tb_router_input_unit.sv
// Directed bench for router_input_unit: vector table plus
// a scoreboarded FIFO wrap sequence.
module tb_router_input_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_flit;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  route_dst_x;
  logic [1:0]  route_dst_y;
  logic [2:0]  route_sel_in;
  logic [31:0] out_flit;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_route;
  logic        out_tail;
  logic        err_drop;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  router_input_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_flit      (in_flit),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .route_dst_x  (route_dst_x),
    .route_dst_y  (route_dst_y),
    .route_sel_in (route_sel_in),
    .out_flit     (out_flit),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_route    (out_route),
    .out_tail     (out_tail),
    .err_drop     (err_drop),
    .count        (count)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] f;
    logic [2:0]  rs;
    logic        ordy;
    logic        ir;
    logic        ov;
    logic [31:0] head;
    logic [2:0]  route;
    logic        tail;
    logic        err;
    int          cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] mk(
    input logic [1:0] t, input logic [7:0] id,
    input logic [1:0] dx, input logic [1:0] dy);
    return {t, 18'd0, id, dy, dx};
  endfunction

  function automatic vec_t v(
    input logic rst, input logic iv, input logic [31:0] f,
    input logic [2:0] rs, input logic ordy,
    input logic ir, input logic ov, input logic [31:0] head,
    input logic [2:0] route, input logic tail, input logic err,
    input int cnt);
    vec_t r;
    r.rst = rst; r.iv = iv; r.f = f; r.rs = rs; r.ordy = ordy;
    r.ir = ir; r.ov = ov; r.head = head; r.route = route;
    r.tail = tail; r.err = err; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [31:0] s1, h, b1, b2, t;
  logic [31:0] ah, at, bh, bt;
  logic [31:0] sb, st, ss;
  logic [31:0] mh, mb, mt;
  logic [31:0] src [10];
  logic [31:0] exp_q[$];

  initial begin
    s1 = mk(2'b11, 8'd1, 2'd2, 2'd1);
    h  = mk(2'b01, 8'd2, 2'd1, 2'd3);
    b1 = mk(2'b00, 8'd3, 2'd0, 2'd0);
    b2 = mk(2'b00, 8'd4, 2'd1, 2'd1);
    t  = mk(2'b10, 8'd5, 2'd2, 2'd2);
    ah = mk(2'b01, 8'd6, 2'd3, 2'd0);
    at = mk(2'b10, 8'd7, 2'd0, 2'd1);
    bh = mk(2'b01, 8'd8, 2'd0, 2'd2);
    bt = mk(2'b10, 8'd9, 2'd3, 2'd3);
    sb = mk(2'b00, 8'd10, 2'd1, 2'd0);
    st = mk(2'b10, 8'd11, 2'd2, 2'd3);
    ss = mk(2'b11, 8'd12, 2'd3, 2'd1);
    mh = mk(2'b01, 8'd13, 2'd1, 2'd1);
    mb = mk(2'b00, 8'd14, 2'd2, 2'd0);
    mt = mk(2'b10, 8'd15, 2'd0, 2'd3);

    // rst iv flit rs ordy | ir ov head route tail err cnt
    tbl.push_back(v(0,0,0, 0,1, 0,0,0, 0,0,0,0));
    // single-flit packet
    tbl.push_back(v(1,1,s1,1,1, 1,0,0, 0,0,0,0));
    tbl.push_back(v(1,0,0, 1,1, 1,0,s1,0,0,0,1));
    tbl.push_back(v(1,0,0, 0,1, 1,1,s1,1,1,0,1));
    tbl.push_back(v(1,0,0, 0,1, 1,0,0, 1,0,0,0));
    // 4-flit packet with back-pressure
    tbl.push_back(v(1,1,h, 3,0, 1,0,0, 1,0,0,0));
    tbl.push_back(v(1,1,b1,3,0, 1,0,h, 1,0,0,1));
    tbl.push_back(v(1,1,b2,3,0, 1,1,h, 3,0,0,2));
    tbl.push_back(v(1,1,t, 3,0, 1,1,h, 3,0,0,3));
    tbl.push_back(v(1,0,0, 3,0, 0,1,h, 3,0,0,4));
    tbl.push_back(v(1,0,0, 3,1, 0,1,h, 3,0,0,4));
    tbl.push_back(v(1,0,0, 3,1, 1,1,b1,3,0,0,3));
    tbl.push_back(v(1,0,0, 3,1, 1,1,b2,3,0,0,2));
    tbl.push_back(v(1,0,0, 3,1, 1,1,t, 3,1,0,1));
    tbl.push_back(v(1,0,0, 3,1, 1,0,0, 3,0,0,0));
    // back-to-back packets
    tbl.push_back(v(1,1,ah,2,1, 1,0,0, 3,0,0,0));
    tbl.push_back(v(1,1,at,2,1, 1,0,ah,3,0,0,1));
    tbl.push_back(v(1,1,bh,2,1, 1,1,ah,2,0,0,2));
    tbl.push_back(v(1,1,bt,2,1, 1,1,at,2,1,0,2));
    tbl.push_back(v(1,0,0, 4,1, 1,0,bh,2,0,0,2));
    tbl.push_back(v(1,0,0, 4,1, 1,1,bh,4,0,0,2));
    tbl.push_back(v(1,0,0, 4,1, 1,1,bt,4,1,0,1));
    tbl.push_back(v(1,0,0, 4,1, 1,0,0, 4,0,0,0));
    // stray body/tail then single
    tbl.push_back(v(1,1,sb,2,1, 1,0,0, 4,0,0,0));
    tbl.push_back(v(1,1,st,2,1, 1,0,sb,4,0,1,1));
    tbl.push_back(v(1,1,ss,2,1, 1,0,st,4,0,1,1));
    tbl.push_back(v(1,0,0, 2,1, 1,0,ss,4,0,0,1));
    tbl.push_back(v(1,0,0, 2,1, 1,1,ss,2,1,0,1));
    tbl.push_back(v(1,0,0, 2,1, 1,0,0, 2,0,0,0));
    // mid-packet reset
    tbl.push_back(v(1,1,mh,3,0, 1,0,0, 2,0,0,0));
    tbl.push_back(v(1,1,mb,3,0, 1,0,mh,2,0,0,1));
    tbl.push_back(v(0,0,0, 3,0, 0,0,mh,3,0,0,2));
    tbl.push_back(v(1,1,mt,0,1, 1,0,0, 0,0,0,0));
    tbl.push_back(v(1,0,0, 0,1, 1,0,mt,0,0,1,1));
    tbl.push_back(v(1,0,0, 0,1, 1,0,0, 0,0,0,0));

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_flit = '0;
    route_sel_in = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n        = tbl[i].rst;
      in_valid     = tbl[i].iv;
      in_flit      = tbl[i].f;
      route_sel_in = tbl[i].rs;
      out_ready    = tbl[i].ordy;
      #1;
      chk($sformatf("r%0d_in_ready", i), in_ready, tbl[i].ir);
      chk($sformatf("r%0d_out_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("r%0d_err_drop", i), err_drop, tbl[i].err);
      chk($sformatf("r%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("r%0d_out_route", i), out_route, tbl[i].route);
      if (tbl[i].cnt != 0) begin
        chk($sformatf("r%0d_out_flit", i), out_flit, tbl[i].head);
        chk($sformatf("r%0d_dst_x", i), route_dst_x,
            {30'd0, tbl[i].head[1:0]});
        chk($sformatf("r%0d_dst_y", i), route_dst_y,
            {30'd0, tbl[i].head[3:2]});
      end
      if (tbl[i].ov)
        chk($sformatf("r%0d_out_tail", i), out_tail, tbl[i].tail);
    end

    // full/wrap: 10-flit packet, out_ready toggling
    src[0] = mk(2'b01, 8'd40, 2'd2, 2'd2);
    for (int k = 1; k < 9; k++)
      src[k] = mk(2'b00, 8'(40 + k), 2'(k), 2'(k + 1));
    src[9] = mk(2'b10, 8'd49, 2'd1, 2'd3);
    begin
      int  sent, rcvd, m_cnt;
      bit  m_act, e_ir, e_ov, do_push, do_pop;
      sent = 0; rcvd = 0; m_cnt = 0; m_act = 1'b0;
      for (int cyc = 0; cyc < 80 && rcvd < 10; cyc++) begin
        @(negedge clk);
        rst_n        = 1'b1;
        route_sel_in = 3'd4;
        out_ready    = (cyc % 2 == 1);
        in_valid     = (sent < 10);
        in_flit      = (sent < 10) ? src[sent] : '0;
        #1;
        e_ir = (m_cnt != 4);
        e_ov = m_act && (m_cnt != 0);
        chk($sformatf("w%0d_count", cyc), count, m_cnt);
        chk($sformatf("w%0d_cnt_le_depth", cyc), count <= 3'd4, 1);
        chk($sformatf("w%0d_in_ready", cyc), in_ready, e_ir);
        chk($sformatf("w%0d_out_valid", cyc), out_valid, e_ov);
        if (e_ov) begin
          chk($sformatf("w%0d_out_flit", cyc), out_flit, exp_q[0]);
          chk($sformatf("w%0d_out_route", cyc), out_route, 3'd4);
        end
        do_push = in_valid && e_ir;
        do_pop  = e_ov && out_ready;
        if (do_push) begin
          exp_q.push_back(src[sent]);
          sent++;
        end
        if (!m_act && m_cnt != 0) m_act = 1'b1;
        else if (do_pop && exp_q[0][31:30] == 2'b10) m_act = 1'b0;
        if (do_pop) begin
          void'(exp_q.pop_front());
          rcvd++;
        end
        m_cnt = m_cnt + int'(do_push) - int'(do_pop);
      end
      chk("wrap_received", rcvd, 10);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/router_input_unit.md
# router_input_unit

Per-port input stage of the mesh router: buffers incoming flits in a small FIFO and presents the head flit's destination to the XY route-computation stage. It latches the returned route once per packet and holds it for every flit of that packet, so the downstream switch sees a stable `out_route` for the whole packet. One instance sits in front of each router input port (local, X+, X-, Y+, Y-).

## Interface
- `X_WIDTH`, default 2: width of the X coordinate.
- `Y_WIDTH`, default 2: width of the Y coordinate.
- `FLIT_WIDTH`, default 32: flit width. Must satisfy ≥ X_WIDTH+Y_WIDTH+2.
- `DEPTH`, default 4: FIFO entries. Must be a power of 2 and ≥ 2.

- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `in_flit`  in  FLIT_WIDTH  incoming flit.
- `in_valid`  in  1  `in_flit` valid.
- `in_ready`  out  1  unit can accept a flit this cycle.
- `route_dst_x`  out  X_WIDTH  dst_x field of the FIFO head flit, driven to route calc.
- `route_dst_y`  out  Y_WIDTH  dst_y field of the FIFO head flit, driven to route calc.
- `route_sel_in`  in  3  combinational route from route calc:
  - 000 local, 001 X+, 010 X-, 011 Y+, 100 Y-.
- `out_flit`  out  FLIT_WIDTH  FIFO head flit.
- `out_valid`  out  1  `out_flit` is valid and routed.
- `out_ready`  in  1  downstream accepts.
- `out_route`  out  3  latched route of the current packet.
- `out_tail`  out  1  `out_flit` is the last flit of its packet.
- `err_drop`  out  1  one-cycle pulse when a stray non-head flit is discarded.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **Flit type:** `flit[FLIT_WIDTH-1:FLIT_WIDTH-2]`.
  - 00 body, 01 head, 10 tail, 11 single (head+tail).
  - Head and single flits carry `dst_x = flit[X_WIDTH-1:0]` and `dst_y = flit[X_WIDTH+Y_WIDTH-1:X_WIDTH]`.
- **FIFO:** circular buffer with wrapping rd/wr pointers and an occupancy counter.
  - Push when `in_valid && in_ready`, where `in_ready = rst_n && (count != DEPTH)`.
  - Pop when the output handshake occurs, or on a drop (below).
  - Simultaneous push and pop leaves `count` unchanged.
  - A push into a full FIFO is impossible, because `in_ready` is 0.
- **`route_dst_x/y`:** always the dst fields of the entry at rd_ptr, regardless of flit type.
- **FSM states:** IDLE, ACTIVE.
  - IDLE, FIFO empty: stay IDLE.
  - IDLE, head type 01: latch `route_sel_in` into the route register and go to ACTIVE. No pop.
  - IDLE, head type 11: latch the route and go to ACTIVE. It is a single-flit packet.
  - IDLE, head type 00 or 10: stray flit. Pop it, pulse `err_drop`, stay IDLE.
  - ACTIVE: `out_valid = (count != 0)`, `out_route` = route register, `out_tail` = head type is 10 or 11.
  - ACTIVE, handshake on a flit with `out_tail` = 1: go to IDLE.
  - ACTIVE, any other handshake: stay ACTIVE.
- **Outputs in IDLE:** `out_valid` = 0. `out_flit` still shows the FIFO head flit.
- **Route register:** holds its value until the next latch. It is never cleared on tail.
- **Stray head flits in ACTIVE:** a head flit arriving in ACTIVE is forwarded as a body flit. Packet framing is the upstream router's responsibility.

## Timing
- **Reset** (rst_n = 0 sampled at a clock edge):
  - pointers and `count` = 0, state = IDLE, route register = 000.
  - `out_valid` = 0, `err_drop` = 0, `in_ready` = 0 while `rst_n` is low.
- **First-flit latency:** a head flit pushed at edge N is at the FIFO head after N.
  - The route is latched at edge N+1.
  - `out_valid` = 1 in the cycle after edge N+1.
  - This gives 2 cycles from input handshake to output valid on an empty unit.
- **Streaming:** body and tail flits stream at 1 flit per cycle while `out_ready` = 1 and the FIFO is non-empty.
- **Packet boundary:** after a tail handshake there is a 1-cycle bubble (`out_valid` = 0) while the next head is routed.
- **Back-pressure:** with `out_ready` = 0 in ACTIVE, `out_flit`, `out_route` and `out_tail` hold stable while `out_valid` = 1.
- **Mid-packet reset:** all FIFO contents are discarded. The next flit must be a head, or it is dropped with `err_drop`.
- **`count`:** registered; it reflects pushes and pops from the previous edge.

## Test plan
- **Single-flit packet:** reset, then push type-11 flit dst (2,1) with `route_sel_in` = 001 and `out_ready` = 1.
  - Required: `out_valid` 2 cycles after the push, `out_route` = 001, `out_tail` = 1.
  - Required: state returns to IDLE and `count` returns to 0.
- **4-flit packet, back-pressure:** head, body, body, tail with `route_sel_in` = 011.
  - Hold `out_ready` = 0 for 3 cycles after `out_valid` rises.
  - Required: `out_flit` and `out_route` stable while stalled, `count` reaches 4, `in_ready` = 0.
  - Required: after release, 4 consecutive handshakes, `out_route` = 011 throughout.
- **Back-to-back packets:** packet A (route 010) followed immediately by packet B (route 100).
  - Required: exactly one idle cycle between A's tail and B's head.
  - Required: B's flits carry `out_route` = 100.
- **Stray flit:** push a body flit, then a tail flit, then a valid single flit, all while in IDLE.
  - Required: two `err_drop` pulses, then the single flit is forwarded normally.
- **Full/wrap:** push 10 flits with `out_ready` toggling each cycle.
  - Required: pointers wrap, no flit is lost or reordered.
  - Required: `count` never exceeds `DEPTH`, and simultaneous push/pop keeps `count` constant.
- **Mid-packet reset:** assert `rst_n` = 0 for 1 cycle after the head and one body flit.
  - Required: `count` = 0, `out_valid` = 0, route register = 000.
  - Required: a subsequent tail flit is dropped with `err_drop`.
